cla_pipe_addsub: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor for wide NTT datapath operands.
- Splits a WIDTH-bit operation into BLOCK-bit slices, one slice per pipeline stage.
- Each stage resolves its slice with in-block generate/propagate lookahead and registers the carry into the next stage.
- Sits between the butterfly operand registers and the modular reduction logic, with a valid/ready stream interface on both sides.

---
 rtl/cla_pipe_addsub_if.sv | 39 +++
 rtl/cla_pipe_addsub.sv | 161 ++++++++++++++++
 tb/tb_cla_pipe_addsub.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cla_pipe_addsub_if.sv
// Stream interface for cla_pipe_addsub: operand beat in, result beat out.
// The modulus q exists only when CLA_MODRED_EN is defined.
interface cla_pipe_addsub_if #(
  parameter int unsigned WIDTH = 128
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef CLA_MODRED_EN
  logic [WIDTH-1:0] q;

  modport master (
    output in_valid, a, b, sub, cin, q, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, sub, cin, q, out_ready,
    output in_ready, out_valid, sum, cout
  );
`else
  modport master (
    output in_valid, a, b, sub, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
`endif
endinterface

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor, one BLOCK-bit slice per stage.
// Stage 0 registers the operands (B already inverted for subtract); stage k
// resolves slice k from its register and hands slice sum and carry onward.
// The last stage resolves its slice combinationally onto the output.
// Optional macro CLA_MODRED_EN adds a modulus input and a registered
// modular correction stage (latency NBLK+1 instead of NBLK).
module cla_pipe_addsub #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned BLOCK = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  cla_pipe_addsub_if.slave bus
);

  localparam int unsigned NBLK = WIDTH / BLOCK;

  // One slice of lookahead: carries flattened from g/p across the slice.
  function automatic logic [BLOCK:0] cla_slice(
    input logic [BLOCK-1:0] x,
    input logic [BLOCK-1:0] y,
    input logic             ci
  );
    logic [BLOCK-1:0] p;
    logic [BLOCK-1:0] g;
    logic [BLOCK:0]   c;
    p    = x ^ y;
    g    = x & y;
    c[0] = ci;
    for (int unsigned i = 0; i < BLOCK; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    return {c[BLOCK], p ^ c[BLOCK-1:0]};
  endfunction

  logic [NBLK-1:0]  v_q, v_d;
  logic [NBLK-1:0]  c_q, c_d;
  logic [WIDTH-1:0] a_q [NBLK];
  logic [WIDTH-1:0] a_d [NBLK];
  logic [WIDTH-1:0] b_q [NBLK];
  logic [WIDTH-1:0] b_d [NBLK];
  logic [WIDTH-1:0] s_q [NBLK];
  logic [WIDTH-1:0] s_d [NBLK];

  logic [BLOCK-1:0] slice_sum [NBLK];
  logic [NBLK-1:0]  slice_co;
  logic [WIDTH-1:0] fsum;
  logic             fcout;
  logic             en;
  logic             out_valid;

  assign en           = !out_valid || bus.out_ready;
  assign bus.in_ready = en;

  // Per-stage slice resolution and the assembled final-stage result.
  always_comb begin
    for (int unsigned k = 0; k < NBLK; k++) begin
      {slice_co[k], slice_sum[k]} = cla_slice(a_q[k][k*BLOCK +: BLOCK],
                                              b_q[k][k*BLOCK +: BLOCK],
                                              c_q[k]);
    end
    fsum = s_q[NBLK-1];
    fsum[(NBLK-1)*BLOCK +: BLOCK] = slice_sum[NBLK-1];
    fcout = slice_co[NBLK-1];
  end

  // Next-state for the skewed pipe: operands and finished low slices travel with the beat.
  always_comb begin
    v_d[0] = bus.in_valid;
    a_d[0] = bus.a;
    b_d[0] = bus.sub ? ~bus.b : bus.b;
    c_d[0] = bus.sub | bus.cin;
    s_d[0] = '0;
    for (int unsigned k = 1; k < NBLK; k++) begin
      v_d[k] = v_q[k-1];
      a_d[k] = a_q[k-1];
      b_d[k] = b_q[k-1];
      c_d[k] = slice_co[k-1];
      s_d[k] = s_q[k-1];
      s_d[k][(k-1)*BLOCK +: BLOCK] = slice_sum[k-1];
    end
  end

  // Pipe registers advance together under the global enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      c_q <= '0;
      for (int unsigned k = 0; k < NBLK; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (en) begin
      v_q <= v_d;
      c_q <= c_d;
      for (int unsigned k = 0; k < NBLK; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
    end
  end

`ifdef CLA_MODRED_EN
  logic [NBLK-1:0]  sub_q, sub_d;
  logic [WIDTH-1:0] m_q [NBLK];
  logic [WIDTH-1:0] m_d [NBLK];
  logic [WIDTH-1:0] r_q, r_d;
  logic             rc_q;
  logic             rv_q;

  // Operation type and modulus ride alongside each beat.
  always_comb begin
    sub_d[0] = bus.sub;
    m_d[0]   = bus.q;
    for (int unsigned k = 1; k < NBLK; k++) begin
      sub_d[k] = sub_q[k-1];
      m_d[k]   = m_q[k-1];
    end
  end

  // Modular correction of the raw result; cout keeps the raw carry.
  always_comb begin
    r_d = fsum;
    if (sub_q[NBLK-1]) begin
      if (!fcout) r_d = fsum + m_q[NBLK-1];
    end else if (fcout || (fsum >= m_q[NBLK-1])) begin
      r_d = fsum - m_q[NBLK-1];
    end
  end

  // Side-band pipe plus the registered correction stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_q <= '0;
      for (int unsigned k = 0; k < NBLK; k++) m_q[k] <= '0;
      r_q  <= '0;
      rc_q <= 1'b0;
      rv_q <= 1'b0;
    end else if (en) begin
      sub_q <= sub_d;
      for (int unsigned k = 0; k < NBLK; k++) m_q[k] <= m_d[k];
      r_q  <= r_d;
      rc_q <= fcout;
      rv_q <= v_q[NBLK-1];
    end
  end

  assign out_valid = rv_q;
  assign bus.sum   = r_q;
  assign bus.cout  = rc_q;
`else
  assign out_valid = v_q[NBLK-1];
  assign bus.sum   = fsum;
  assign bus.cout  = fcout;
`endif

  assign bus.out_valid = out_valid;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Self-checking bench for cla_pipe_addsub (default build or CLA_MODRED_EN).
module tb_cla_pipe_addsub;

  localparam int unsigned WIDTH = 128;
  localparam int unsigned BLOCK = 32;
  localparam int unsigned NBLK  = WIDTH / BLOCK;
`ifdef CLA_MODRED_EN
  localparam int unsigned LAT = NBLK + 1;
`else
  localparam int unsigned LAT = NBLK;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  cla_pipe_addsub_if #(.WIDTH(WIDTH)) bus ();

  cla_pipe_addsub #(.WIDTH(WIDTH), .BLOCK(BLOCK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int               n_cmp = 0;
  int               n_err = 0;
  logic [WIDTH:0]   exp_q [$];
  logic [WIDTH-1:0] q_mod;

  // Reference: plain integer arithmetic; result packed as {cout, sum}.
  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                           input logic s, input logic ci);
    logic [WIDTH+1:0] t;
    logic             co;
    logic [WIDTH-1:0] r;
    if (s) begin
      co = (x >= y);
      r  = x - y;
    end else begin
      t  = {2'b00, x} + {2'b00, y} + {{(WIDTH+1){1'b0}}, ci};
      co = t[WIDTH];
      r  = t[WIDTH-1:0];
    end
`ifdef CLA_MODRED_EN
    if (s) begin
      t = co ? ({2'b00, x} - {2'b00, y}) : ({2'b00, x} + {2'b00, q_mod} - {2'b00, y});
    end else begin
      t = {2'b00, x} + {2'b00, y} + {{(WIDTH+1){1'b0}}, ci};
      if (t >= {2'b00, q_mod}) t = t - {2'b00, q_mod};
    end
    r = t[WIDTH-1:0];
`endif
    return {co, r};
  endfunction

  function automatic logic [WIDTH-1:0] rand_word();
    logic [WIDTH-1:0] w;
    w = '0;
    for (int i = 0; i < int'(WIDTH); i += 32) w = (w << 32) | WIDTH'($urandom());
`ifdef CLA_MODRED_EN
    w = w % q_mod;
`endif
    return w;
  endfunction

  task automatic set_beat(input logic v, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input logic s, input logic ci);
    bus.in_valid = v;
    bus.a        = x;
    bus.b        = y;
    bus.sub      = s;
    bus.cin      = ci;
  endtask

  // Drives one beat through an idle pipe; reports the result and cycles to out_valid.
  task automatic run_one(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s,
                         input logic ci, output logic [WIDTH-1:0] rs, output logic rc,
                         output int lat);
    bus.out_ready = 1'b1;
    set_beat(1'b1, x, y, s, ci);
    @(negedge clk);
    set_beat(1'b0, '0, '0, 1'b0, 1'b0);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rs = bus.sum;
    rc = bus.cout;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.sum !== '0 || bus.cout !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: out_valid=%b sum=%h cout=%b, required 0/0/0",
               bus.out_valid, bus.sum, bus.cout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready);
    end
    @(negedge clk);
  endtask

`ifndef CLA_MODRED_EN
  task automatic test_directed();
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] e;
    logic [WIDTH-1:0] rs;
    logic             rc;
    int               lat;
    ones = '1;
    for (int unsigned t = 0; t < 5; t++) begin
      logic s, ci, ec;
      case (t)
        0: begin x = ones; y = '0; s = 0; ci = 1; e = '0; ec = 1; end
        1: begin x = WIDTH'(64'hFFFF_FFFF); y = WIDTH'(1); s = 0; ci = 0; e = WIDTH'(64'h1_0000_0000); ec = 0; end
        2: begin x = WIDTH'(5); y = WIDTH'(7); s = 1; ci = 0; e = ones - WIDTH'(1); ec = 0; end
        3: begin x = WIDTH'(7); y = WIDTH'(5); s = 1; ci = 1; e = WIDTH'(2); ec = 1; end
        default: begin x = ones; y = ones; s = 0; ci = 1; e = ones; ec = 1; end
      endcase
      run_one(x, y, s, ci, rs, rc, lat);
      n_cmp++;
      if (rs !== e || rc !== ec) begin
        n_err++;
        $display("FAIL directed_%0d: sum=%h cout=%b, required sum=%h cout=%b", t, rs, rc, e, ec);
      end
      n_cmp++;
      if (lat != int'(LAT)) begin
        n_err++;
        $display("FAIL directed_lat_%0d: latency %0d, required %0d", t, lat, LAT);
      end
    end
  endtask
`endif

  task automatic test_back_to_back();
    int unsigned      sent = 0;
    int unsigned      got = 0;
    int unsigned      cyc = 0;
    int unsigned      extra = 0;
    logic             prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_sum = '0;
    logic             prev_cout = 1'b0;
    logic             exp_rdy;
    while (got < 16 && cyc < 200) begin
      bus.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      if (sent < 16) set_beat(1'b1, WIDTH'(sent), WIDTH'(3 * sent), 1'b0, 1'b0);
      else           set_beat(1'b0, '0, '0, 1'b0, 1'b0);
      #1;
      exp_rdy = !(bus.out_valid && !bus.out_ready);
      n_cmp++;
      if (bus.in_ready !== exp_rdy) begin
        n_err++;
        $display("FAIL b2b_in_ready cyc %0d: got %b, required %b", cyc, bus.in_ready, exp_rdy);
      end
      if (prev_stall) begin
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.sum !== prev_sum || bus.cout !== prev_cout) begin
          n_err++;
          $display("FAIL b2b_stall cyc %0d: valid=%b sum=%h cout=%b, required 1/%h/%b",
                   cyc, bus.out_valid, bus.sum, bus.cout, prev_sum, prev_cout);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        n_cmp++;
        if ({bus.cout, bus.sum} !== {1'b0, WIDTH'(4 * got)}) begin
          n_err++;
          $display("FAIL b2b_result_%0d: sum=%h cout=%b, required sum=%h cout=0",
                   got, bus.sum, bus.cout, WIDTH'(4 * got));
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_sum   = bus.sum;
      prev_cout  = bus.cout;
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (got != 16) begin
      n_err++;
      $display("FAIL b2b_count: received %0d results, required 16", got);
    end
    bus.out_ready = 1'b1;
    set_beat(1'b0, '0, '0, 1'b0, 1'b0);
    for (int unsigned i = 0; i < 2 * LAT; i++) begin
      #1;
      if (bus.out_valid) extra++;
      @(negedge clk);
    end
    n_cmp++;
    if (extra != 0) begin
      n_err++;
      $display("FAIL b2b_extra: %0d extra results, required 0", extra);
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             s;
    logic             ci;
    logic [WIDTH:0]   e;
    int unsigned      cyc = 0;
    exp_q.delete();
    while (cyc < 300 || (exp_q.size() != 0 && cyc < 400)) begin
      x = rand_word();
      y = rand_word();
      s = 1'($urandom());
      ci = 1'($urandom());
      set_beat((cyc < 300) && ($urandom_range(9) < 7), x, y, s, ci);
      bus.out_ready = (cyc >= 300) || ($urandom_range(9) < 6);
      #1;
      if (bus.out_valid && bus.out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL rand_unexpected cyc %0d: sum=%h with no beat outstanding", cyc, bus.sum);
        end else begin
          e = exp_q.pop_front();
          if ({bus.cout, bus.sum} !== e) begin
            n_err++;
            $display("FAIL rand_result cyc %0d: sum=%h cout=%b, required sum=%h cout=%b",
                     cyc, bus.sum, bus.cout, e[WIDTH-1:0], e[WIDTH]);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(model(x, y, s, ci));
      @(negedge clk);
      cyc++;
    end
    set_beat(1'b0, '0, '0, 1'b0, 1'b0);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL rand_drain: %0d results outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_midflight();
    int unsigned      wait_c = 0;
    int unsigned      stale = 0;
    logic [WIDTH-1:0] rs;
    logic             rc;
    int               lat;
    bus.out_ready = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      set_beat(1'b1, WIDTH'(i + 1), WIDTH'(i + 2), 1'b0, 1'b0);
      @(negedge clk);
    end
    set_beat(1'b0, '0, '0, 1'b0, 1'b0);
    while (!bus.out_valid && wait_c < 10) begin
      @(negedge clk);
      wait_c++;
    end
    n_cmp++;
    if (bus.out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_prefill: out_valid=%b, required 1", bus.out_valid);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_clear: out_valid=%b in_ready=%b, required 0/1", bus.out_valid, bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int unsigned i = 0; i < 10; i++) begin
      #1;
      if (bus.out_valid) stale++;
      @(negedge clk);
    end
    n_cmp++;
    if (stale != 0) begin
      n_err++;
      $display("FAIL midrst_stale: %0d stale results, required 0", stale);
    end
    run_one(WIDTH'(5), WIDTH'(9), 1'b0, 1'b0, rs, rc, lat);
    n_cmp++;
    if (rs !== WIDTH'(14) || rc !== 1'b0 || lat != int'(LAT)) begin
      n_err++;
      $display("FAIL midrst_next: sum=%h cout=%b lat=%0d, required sum=e cout=0 lat=%0d", rs, rc, lat, LAT);
    end
  endtask

`ifdef CLA_MODRED_EN
  task automatic test_modred();
    logic [WIDTH-1:0] rs;
    logic             rc;
    int               lat;
    run_one(q_mod - WIDTH'(1), WIDTH'(2), 1'b0, 1'b0, rs, rc, lat);
    n_cmp++;
    if (rs !== WIDTH'(1) || lat != int'(NBLK + 1)) begin
      n_err++;
      $display("FAIL modred_add: sum=%h lat=%0d, required sum=1 lat=%0d", rs, lat, NBLK + 1);
    end
    run_one(WIDTH'(1), WIDTH'(2), 1'b1, 1'b0, rs, rc, lat);
    n_cmp++;
    if (rs !== q_mod - WIDTH'(1) || rc !== 1'b0) begin
      n_err++;
      $display("FAIL modred_sub: sum=%h cout=%b, required sum=%h cout=0", rs, rc, q_mod - WIDTH'(1));
    end
  endtask
`endif

  initial begin
    q_mod = WIDTH'(64'hFFFF_FFFF_0000_0001);
`ifdef CLA_MODRED_EN
    bus.q = q_mod;
`endif
    bus.out_ready = 1'b0;
    set_beat(1'b0, '0, '0, 1'b0, 1'b0);
    test_reset();
`ifdef CLA_MODRED_EN
    test_modred();
`else
    test_directed();
`endif
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
